// File: rtl/dst_wb_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dst_wb_writer_pkg
//  Purpose  : Shared FSM encodings and Wishbone constants for dst_wb_writer.
//  Revision : 1.0  initial release
// ============================================================================
package dst_wb_writer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_LOAD  = 3'd2,
        S_WRITE = 3'd3,
        S_GAP   = 3'd4,
        S_ERR   = 3'd5,
        S_DONE  = 3'd6,
        S_WAIT  = 3'd7
    } state_t;

    localparam logic [2:0] CTI_INCR  = 3'b010;
    localparam logic [2:0] CTI_EOB   = 3'b111;
    localparam int         PAGE_BITS = 12;

endpackage
`default_nettype wire

// File: rtl/dst_wb_sel.sv
`default_nettype none
// ============================================================================
//  Module   : dst_wb_sel
//  Purpose  : Byte count -> number of 64-bit words and final-word byte enables.
//  Revision : 1.0  initial release
// ============================================================================
module dst_wb_sel
    import dst_wb_writer_pkg::*;
(
    input  logic [23:0] i_len,
    output logic [21:0] o_words,
    output logic [7:0]  o_last_sel
);

    always_comb begin
        o_words    = {1'b0, i_len[23:3]} + {21'd0, |i_len[2:0]};
        o_last_sel = (i_len[2:0] == 3'd0) ? 8'hFF : ((8'd1 << i_len[2:0]) - 8'd1);
    end

endmodule
`default_nettype wire

// File: rtl/dst_wb_writer.sv
`default_nettype none
// ============================================================================
//  Module   : dst_wb_writer
//  Purpose  : Drains the destination FIFO into memory as a Wishbone burst master.
//             Optional running checksum output enabled by DST_WR_CSUM_EN.
//  Revision : 1.0  initial release
// ============================================================================
module dst_wb_writer
    import dst_wb_writer_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int AW        = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wr_enable,
    input  logic [AW-1:0] dst_adr,
    input  logic [23:0]   dst_len,
    output logic          f_getn,
    input  logic [63:0]   f_dat,
    input  logic          f_last,
    input  logic          f_empty,
    output logic [AW-1:0] wbm_adr_o,
    output logic [63:0]   wbm_dat_o,
    output logic [7:0]    wbm_sel_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic          wbm_we_o,
    output logic [2:0]    wbm_cti_o,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i,
    output logic          wr_endn,
`ifdef DST_WR_CSUM_EN
    output logic [31:0]   wr_csum,
`endif
    output logic          wr_err
);

    localparam logic [4:0] c_BEAT_LAST = 5'(MAX_BURST - 1);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_adr;
    logic [21:0]   r_words;
    logic [7:0]    r_last_sel;
    logic [4:0]    r_beat;
    logic          r_burst;
    logic [63:0]   r_dat;
    logic          r_last;
    logic          r_err;

    logic [21:0]   w_words;
    logic [7:0]    w_last_sel;
    logic          w_final_word;
    logic          w_burst_end;
    logic          w_early_last;

    dst_wb_sel u_sel (
        .i_len      (dst_len),
        .o_words    (w_words),
        .o_last_sel (w_last_sel)
    );

    assign w_final_word = (r_words == 22'd1);
    // The next word address would land on a new 4 KB page.
    assign w_burst_end  = (r_beat == c_BEAT_LAST) || (&r_adr[PAGE_BITS-1:3]);
    assign w_early_last = r_last && (r_words > 22'd1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        f_getn    = 1'b1;
        wr_endn   = 1'b1;
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_sel_o = 8'h00;
        wbm_cti_o = 3'b000;
        case (r_state)
            S_IDLE: begin
                if (wr_enable) begin
                    w_next = (dst_len == 24'd0) ? S_DONE : S_POP;
                end
            end
            S_POP: begin
                // An open burst survives the pop only while data is on hand.
                wbm_cyc_o = r_burst && !f_empty;
                if (!f_empty) begin
                    f_getn = 1'b0;
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                wbm_cyc_o = r_burst;
                w_next    = S_WRITE;
            end
            S_WRITE: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_sel_o = w_final_word ? r_last_sel : 8'hFF;
                wbm_cti_o = (w_final_word || w_burst_end) ? CTI_EOB : CTI_INCR;
                if (wbm_err_i) begin
                    w_next = S_ERR;
                end else if (wbm_ack_i) begin
                    if (w_early_last) begin
                        w_next = S_ERR;
                    end else if (w_final_word) begin
                        w_next = S_DONE;
                    end else if (w_burst_end) begin
                        w_next = S_GAP;
                    end else begin
                        w_next = S_POP;
                    end
                end
            end
            S_GAP:  w_next = S_POP;
            S_ERR:  w_next = S_DONE;
            S_DONE: begin
                wr_endn = 1'b0;
                w_next  = wr_enable ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!wr_enable) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        wbm_we_o = wbm_cyc_o;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_adr      <= '0;
            r_words    <= '0;
            r_last_sel <= '0;
            r_beat     <= '0;
            r_burst    <= 1'b0;
            r_dat      <= '0;
            r_last     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (wr_enable) begin
                        r_adr      <= dst_adr & ~AW'(7);
                        r_words    <= w_words;
                        r_last_sel <= w_last_sel;
                        r_err      <= 1'b0;
                        r_beat     <= '0;
                        r_burst    <= 1'b0;
                    end
                end
                S_POP: begin
                    if (f_empty) begin
                        r_burst <= 1'b0;
                        r_beat  <= '0;
                    end
                end
                S_LOAD: begin
                    r_dat   <= f_dat;
                    r_last  <= f_last;
                    r_burst <= 1'b1;
                end
                S_WRITE: begin
                    if (wbm_err_i) begin
                        r_burst <= 1'b0;
                        r_beat  <= '0;
                    end else if (wbm_ack_i) begin
                        r_adr   <= r_adr + AW'(8);
                        r_words <= r_words - 22'd1;
                        if (w_final_word || w_burst_end || w_early_last) begin
                            r_burst <= 1'b0;
                            r_beat  <= '0;
                        end else begin
                            r_beat <= r_beat + 5'd1;
                        end
                    end
                end
                // Re-open immediately so cyc is low for the gap cycle only.
                S_GAP:   r_burst <= 1'b1;
                S_ERR:   r_err   <= 1'b1;
                default: ;
            endcase
        end
    end

    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign wr_err    = r_err;

`ifdef DST_WR_CSUM_EN
    logic [31:0] r_csum;
    logic [63:0] w_csum_dat;

    always_comb begin
        for (int b = 0; b < 8; b++) begin
            w_csum_dat[b*8 +: 8] = wbm_sel_o[b] ? r_dat[b*8 +: 8] : 8'h00;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_csum <= '0;
        end else if (r_state == S_IDLE && wr_enable) begin
            r_csum <= '0;
        end else if (r_state == S_WRITE && wbm_ack_i && !wbm_err_i) begin
            r_csum <= r_csum + w_csum_dat[63:32] + w_csum_dat[31:0];
        end
    end

    assign wr_csum = r_csum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dst_wb_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dst_wb_writer
//  Purpose  : Directed self-checking bench for dst_wb_writer (FIFO + WB slave models).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dst_wb_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_enable = 1'b0;
    logic [31:0] dst_adr = '0;
    logic [23:0] dst_len = '0;
    logic        f_getn;
    logic [63:0] f_dat = '0;
    logic        f_last = 1'b0;
    logic        f_empty = 1'b1;
    logic [31:0] wbm_adr_o;
    logic [63:0] wbm_dat_o;
    logic [7:0]  wbm_sel_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [2:0]  wbm_cti_o;
    logic        wbm_ack_i, wbm_err_i;
    logic        wr_endn, wr_err;
`ifdef DST_WR_CSUM_EN
    logic [31:0] wr_csum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dst_wb_writer #(.MAX_BURST(8), .AW(32)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wr_enable (wr_enable),
        .dst_adr   (dst_adr),
        .dst_len   (dst_len),
        .f_getn    (f_getn),
        .f_dat     (f_dat),
        .f_last    (f_last),
        .f_empty   (f_empty),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_cti_o (wbm_cti_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i),
        .wr_endn   (wr_endn),
`ifdef DST_WR_CSUM_EN
        .wr_csum   (wr_csum),
`endif
        .wr_err    (wr_err)
    );

    // FIFO model: data appears the cycle after a pop; starve forces empty.
    logic [64:0] q[$];
    logic        starve = 1'b0;
    always @(posedge clk) begin
        int sz;
        sz = q.size();
        if (!f_getn && sz > 0) begin
            f_dat  <= q[0][63:0];
            f_last <= q[0][64];
            q.pop_front();
            sz = sz - 1;
        end
        f_empty <= starve || (sz == 0);
    end

    // Zero-wait slave; err replaces ack on the beat numbered err_beat.
    int err_beat = -1;
    int n_beats = 0, n_pops = 0, n_endn = 0, n_bursts = 0, low_run = 0, last_gap = 0;
    logic cyc_q = 1'b0;
    assign wbm_err_i = wbm_cyc_o && wbm_stb_o && (n_beats == err_beat);
    assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && !wbm_err_i;

    logic [31:0] log_adr[256];
    logic [63:0] log_dat[256];
    logic [7:0]  log_sel[256];
    logic [2:0]  log_cti[256];

    always @(posedge clk) begin
        if (wbm_cyc_o && wbm_stb_o && n_beats < 256) begin
            log_adr[n_beats] <= wbm_adr_o;
            log_dat[n_beats] <= wbm_dat_o;
            log_sel[n_beats] <= wbm_sel_o;
            log_cti[n_beats] <= wbm_cti_o;
            n_beats <= n_beats + 1;
        end
        if (!f_getn) n_pops <= n_pops + 1;
        if (!wr_endn) n_endn <= n_endn + 1;
        if (wbm_cyc_o && !cyc_q) begin
            n_bursts <= n_bursts + 1;
            last_gap <= low_run;
        end
        low_run <= wbm_cyc_o ? 0 : low_run + 1;
        cyc_q   <= wbm_cyc_o;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int t, input int i);
        return {32'h1111_0000 + 32'(t * 256 + i), 32'h2222_0000 + 32'(i * 16 + t)};
    endfunction

`ifdef DST_WR_CSUM_EN
    function automatic logic [31:0] csum_word(input logic [63:0] d, input logic [7:0] s);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[b*8 +: 8] = s[b] ? d[b*8 +: 8] : 8'h00;
        return m[63:32] + m[31:0];
    endfunction
`endif

    task automatic push_words(input int t, input int n, input int last_idx);
        for (int i = 0; i < n; i++) q.push_back({(i == last_idx), mk(t, i)});
    endtask

    task automatic start_xfer(input string tag, input logic [31:0] adr, input logic [23:0] len,
                              output int lat);
        @(negedge clk);
        dst_adr   = adr;
        dst_len   = len;
        wr_enable = 1'b1;
        @(negedge clk);
        wr_enable = 1'b0;
        lat = 1;
        while (wr_endn && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_endn_seen"}, {63'd0, ~wr_endn}, 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic verify_beats(input string tag, input int b0, input int t, input logic [31:0] adr0,
                                input int n, input logic [7:0] lsel, input logic [47:0] ctis,
                                input bit do_cti);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_adr%0d", tag, i), {32'd0, log_adr[b0+i]}, {32'd0, adr0 + 32'(8*i)});
            check($sformatf("%s_dat%0d", tag, i), log_dat[b0+i], mk(t, i));
            check($sformatf("%s_sel%0d", tag, i), {56'd0, log_sel[b0+i]},
                  {56'd0, (i == n-1) ? lsel : 8'hFF});
            if (do_cti)
                check($sformatf("%s_cti%0d", tag, i), {61'd0, log_cti[b0+i]}, {61'd0, ctis[i*3 +: 3]});
        end
    endtask

    initial begin
        int b0, p0, e0, r0, lat, waited;
`ifdef DST_WR_CSUM_EN
        logic [31:0] exp_sum;
`endif
        repeat (3) @(negedge clk);
        check("rst_getn", {63'd0, f_getn}, 64'd1);
        check("rst_endn", {63'd0, wr_endn}, 64'd1);
        check("rst_cyc",  {61'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 64'd0);
        check("rst_cti",  {61'd0, wbm_cti_o}, 64'd0);
        check("rst_sel",  {56'd0, wbm_sel_o}, 64'd0);
        check("rst_adr",  {32'd0, wbm_adr_o}, 64'd0);
        check("rst_dat",  wbm_dat_o, 64'd0);
        check("rst_err",  {63'd0, wr_err}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1) one full 8-beat burst
        push_words(1, 8, -1);
        b0 = n_beats; p0 = n_pops; e0 = n_endn; r0 = n_bursts;
        start_xfer("t1", 32'h1000, 24'd64, lat);
        check("t1_beats", 64'(n_beats - b0), 64'd8);
        check("t1_bursts", 64'(n_bursts - r0), 64'd1);
        check("t1_endn_cnt", 64'(n_endn - e0), 64'd1);
        check("t1_pops", 64'(n_pops - p0), 64'd8);
        check("t1_err", {63'd0, wr_err}, 64'd0);
        verify_beats("t1", b0, 1, 32'h1000, 8, 8'hFF, {24'd0, 3'b111, {7{3'b010}}}, 1'b1);
`ifdef DST_WR_CSUM_EN
        exp_sum = '0;
        for (int i = 0; i < 8; i++) exp_sum += csum_word(mk(1, i), 8'hFF);
        check("t1_csum", {32'd0, wr_csum}, {32'd0, exp_sum});
`endif

        // 2) len=20: three writes, partial last word, 4th word stays in FIFO
        push_words(2, 4, -1);
        b0 = n_beats; p0 = n_pops;
        start_xfer("t2", 32'h2000, 24'd20, lat);
        check("t2_beats", 64'(n_beats - b0), 64'd3);
        check("t2_pops", 64'(n_pops - p0), 64'd3);
        check("t2_left", 64'(q.size()), 64'd1);
        verify_beats("t2", b0, 2, 32'h2000, 3, 8'h0F, {39'd0, 3'b111, 3'b010, 3'b010}, 1'b1);
`ifdef DST_WR_CSUM_EN
        exp_sum = csum_word(mk(2, 0), 8'hFF) + csum_word(mk(2, 1), 8'hFF) + csum_word(mk(2, 2), 8'h0F);
        check("t2_csum", {32'd0, wr_csum}, {32'd0, exp_sum});
`endif
        q.delete();
        repeat (2) @(negedge clk);

        // 3) 4 KB page crossing splits the transfer into two bursts
        push_words(3, 4, -1);
        b0 = n_beats; r0 = n_bursts;
        start_xfer("t3", 32'h0FF0, 24'd32, lat);
        check("t3_beats", 64'(n_beats - b0), 64'd4);
        check("t3_bursts", 64'(n_bursts - r0), 64'd2);
        check("t3_gap", 64'(last_gap), 64'd1);
        verify_beats("t3", b0, 3, 32'h0FF0, 4, 8'hFF, {36'd0, 3'b111, 3'b010, 3'b111, 3'b010}, 1'b1);

        // 4) bus error on beat 2 of 4
        push_words(4, 4, -1);
        b0 = n_beats; p0 = n_pops; e0 = n_endn;
        err_beat = n_beats + 1;
        start_xfer("t4", 32'h3000, 24'd32, lat);
        err_beat = -1;
        check("t4_err", {63'd0, wr_err}, 64'd1);
        check("t4_beats", 64'(n_beats - b0), 64'd2);
        check("t4_pops", 64'(n_pops - p0), 64'd2);
        check("t4_endn_cnt", 64'(n_endn - e0), 64'd1);
        check("t4_cyc", {63'd0, wbm_cyc_o}, 64'd0);
        verify_beats("t4", b0, 4, 32'h3000, 2, 8'hFF, 48'd0, 1'b0);
        q.delete();
        repeat (2) @(negedge clk);

        // 5a) f_last on word 3 of 8: early end of stream
        push_words(5, 8, 2);
        b0 = n_beats; p0 = n_pops;
        start_xfer("t5", 32'h4000, 24'd64, lat);
        check("t5_err", {63'd0, wr_err}, 64'd1);
        check("t5_beats", 64'(n_beats - b0), 64'd3);
        check("t5_pops", 64'(n_pops - p0), 64'd3);
        verify_beats("t5", b0, 5, 32'h4000, 3, 8'hFF, 48'd0, 1'b0);
        q.delete();
        repeat (2) @(negedge clk);

        // 5b) zero-length transfer: quick done, no bus traffic, error cleared
        b0 = n_beats; p0 = n_pops; r0 = n_bursts;
        start_xfer("t5z", 32'h4800, 24'd0, lat);
        check("t5z_lat_le2", {63'd0, (lat <= 2)}, 64'd1);
        check("t5z_beats", 64'(n_beats - b0), 64'd0);
        check("t5z_bursts", 64'(n_bursts - r0), 64'd0);
        check("t5z_pops", 64'(n_pops - p0), 64'd0);
        check("t5z_err", {63'd0, wr_err}, 64'd0);

        // 6a) FIFO running dry intermittently
        push_words(6, 5, -1);
        b0 = n_beats; p0 = n_pops;
        fork
            start_xfer("t6", 32'h5000, 24'd40, lat);
            begin
                for (int k = 0; k < 24; k++) begin
                    @(negedge clk);
                    starve = (k % 3) != 2;
                end
                starve = 1'b0;
            end
        join
        check("t6_beats", 64'(n_beats - b0), 64'd5);
        check("t6_pops", 64'(n_pops - p0), 64'd5);
        verify_beats("t6", b0, 6, 32'h5000, 5, 8'hFF, {33'd0, 3'b111, {4{3'b010}}}, 1'b1);

        // 6b) reset in the middle of a burst
        push_words(7, 8, -1);
        b0 = n_beats; e0 = n_endn;
        @(negedge clk);
        dst_adr = 32'h6000; dst_len = 24'd64; wr_enable = 1'b1;
        @(negedge clk);
        wr_enable = 1'b0;
        waited = 0;
        while ((n_beats - b0) < 3 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("t6r_reached", {63'd0, ((n_beats - b0) >= 3)}, 64'd1);
        check("t6r_cyc_busy", {63'd0, wbm_cyc_o}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6r_cyc", {61'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 64'd0);
        check("t6r_getn", {63'd0, f_getn}, 64'd1);
        check("t6r_endn", {63'd0, wr_endn}, 64'd1);
        check("t6r_adr", {32'd0, wbm_adr_o}, 64'd0);
        check("t6r_dat", wbm_dat_o, 64'd0);
        check("t6r_sel_cti", {53'd0, wbm_sel_o, wbm_cti_o}, 64'd0);
`ifdef DST_WR_CSUM_EN
        check("t6r_csum", {32'd0, wr_csum}, 64'd0);
`endif
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t6r_no_endn", 64'(n_endn - e0), 64'd0);
        check("t6r_idle_cyc", {63'd0, wbm_cyc_o}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
